// File: rtl/ascii_number_parser.sv
// ascii_number_parser: iterative ASCII decimal accumulator with valid/ready handshakes
module ascii_number_parser #(
  parameter int MAX_DIGITS = 6,
  parameter logic [7:0] TERM_CHAR = 8'h0D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [19:0] out_value,
  output logic [2:0]  out_count,
  output logic        out_error,
  output logic        out_valid,
  input  logic        out_ready
);
  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;
  state_t state;
  logic [19:0] acc;
  logic [2:0] cnt;
  logic err;
  logic is_digit, is_term;
  logic [19:0] acc_next;
  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_term = in_data == TERM_CHAR;
  assign acc_next = (acc << 3) + (acc << 1) + {16'd0, in_data[3:0]};
  assign in_ready = state != DONE;
  // parser state, accumulator and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      err <= 1'b0;
      out_value <= '0;
      out_count <= '0;
      out_error <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (is_digit) begin
            acc <= {16'd0, in_data[3:0]};
            cnt <= 3'd1;
            state <= ACCUM;
          end else if (is_term) begin
            out_value <= '0;
            out_count <= '0;
            out_error <= 1'b1;
            out_valid <= 1'b1;
            state <= DONE;
          end else begin
            err <= 1'b1;
            state <= FLUSH;
          end
        end
        ACCUM: if (in_valid) begin
          if (is_digit && cnt < 3'(MAX_DIGITS)) begin
            acc <= acc_next;
            cnt <= cnt + 3'd1;
          end else if (is_term) begin
            out_value <= acc;
            out_count <= cnt;
            out_error <= 1'b0;
            out_valid <= 1'b1;
            state <= DONE;
          end else begin
            err <= 1'b1;
            state <= FLUSH;
          end
        end
        FLUSH: if (in_valid && is_term) begin
          out_value <= '0;
          out_count <= cnt;
          out_error <= err;
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (out_ready) begin
          acc <= '0;
          cnt <= '0;
          err <= 1'b0;
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ascii_number_parser.sv
// tb_ascii_number_parser: directed and randomized checks against a decimal-string reference model
module tb_ascii_number_parser;
  logic clk = 0, rst_n = 0;
  logic [7:0] in_data = 8'h00;
  logic in_valid = 0, out_ready = 0;
  logic in_ready, out_error, out_valid;
  logic [19:0] out_value;
  logic [2:0] out_count;
  int total = 0, bad = 0;

  ascii_number_parser dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_value(out_value), .out_count(out_count), .out_error(out_error),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // reference model: number kept as plain integer plus digit count and a malformed flag
  bit m_pend, m_bad;
  int m_acc, m_n, e_val, e_cnt, e_err;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 0; m_bad = 0; m_acc = 0; m_n = 0; e_val = 0; e_cnt = 0; e_err = 0;
    end else if (m_pend) begin
      if (out_ready) m_pend = 0;
    end else if (in_valid) begin
      if (in_data == 8'h0D) begin
        m_pend = 1;
        e_err = (m_bad || m_n == 0) ? 1 : 0;
        e_val = e_err ? 0 : m_acc;
        e_cnt = m_n;
        m_acc = 0; m_n = 0; m_bad = 0;
      end else if (!m_bad) begin
        if (in_data >= "0" && in_data <= "9" && m_n < 6) begin
          m_acc = m_acc * 10 + int'(in_data - "0");
          m_n++;
        end else m_bad = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("valid", int'(out_valid), int'(m_pend));
    chk("in_ready", int'(in_ready), int'(!m_pend));
    chk("value", int'(out_value), e_val);
    chk("count", int'(out_count), e_cnt);
    chk("error", int'(out_error), e_err);
  end

  task automatic send_str(input string s);
    int k;
    logic r;
    for (int i = 0; i < s.len(); i++) begin
      in_valid = 1;
      in_data = s[i];
      k = 0;
      do begin
        r = in_ready;
        @(posedge clk); #2;
        k++;
      end while (!r && k < 20);
      if (!r) chk("send_timeout", 0, 1);
    end
    in_valid = 0;
  endtask

  task automatic take(input string name, input int v, input int c, input int e);
    chk({name, "_valid"}, int'(out_valid), 1);
    chk({name, "_value"}, int'(out_value), v);
    chk({name, "_count"}, int'(out_count), c);
    chk({name, "_error"}, int'(out_error), e);
    out_ready = 1;
    @(posedge clk); #2;
    out_ready = 0;
    chk({name, "_released"}, int'(out_valid), 0);
  endtask

  initial begin
    logic rdy;
    int r;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_value", int'(out_value), 0);
    rst_n = 1;
    @(posedge clk); #2;
    send_str("123\r");
    take("t123", 'h7B, 3, 0);
    send_str("999999\r");
    take("t999999", 'hF423F, 6, 0);
    send_str("0\r");
    take("t0", 0, 1, 0);
    send_str("1234567\r");
    take("t7dig", 0, 6, 1);
    send_str("5\r");
    take("t5", 5, 1, 0);
    send_str("12A4\r");
    take("tbadchar", 0, 2, 1);
    send_str("\r");
    take("tlonecr", 0, 0, 1);
    send_str("3\r");
    in_valid = 1;
    in_data = "7";
    for (int i = 0; i < 5; i++) begin
      chk("hold_ready", int'(in_ready), 0);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_value", int'(out_value), 3);
      @(posedge clk); #2;
    end
    out_ready = 1;
    @(posedge clk); #2;
    out_ready = 0;
    chk("hold_release_ready", int'(in_ready), 1);
    @(posedge clk); #2;
    send_str("\r");
    take("t7held", 7, 1, 0);
    send_str("45");
    rst_n = 0;
    @(posedge clk); #2;
    chk("midrst_valid", int'(out_valid), 0);
    @(posedge clk); #2;
    rst_n = 1;
    @(posedge clk); #2;
    chk("postrst_valid", int'(out_valid), 0);
    send_str("8\r");
    take("t8", 8, 1, 0);
    rdy = 0;
    for (int i = 0; i < 3000; i++) begin
      rst_n = (i != 1500);
      if (!in_valid || rdy) begin
        in_valid = $urandom_range(0, 3) != 0;
        r = $urandom_range(0, 9);
        in_data = (r <= 5) ? 8'(8'h30 + $urandom_range(0, 9)) : (r <= 7) ? 8'h0D : (r == 8) ? "A" : " ";
      end
      out_ready = $urandom_range(0, 1) != 0;
      rdy = in_ready;
      @(posedge clk); #2;
    end
    rst_n = 1;
    in_valid = 0;
    out_ready = 1;
    repeat (3) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ascii_number_parser.md
# ascii_number_parser

Sequencing controller for the ASCII digit decode datapath. Accepts a byte stream of ASCII characters (typically from the UART receive path) over a valid/ready handshake, decodes each digit character to its binary weight, and accumulates the digits MSB-first into a 20-bit binary value. A terminator character closes the number and presents the result, digit count and error flag on a valid/ready output handshake. Replaces the fixed per-position decoders (units, tens, hundreds, ...) with one iterative multiply-by-ten accumulator, so numbers of any length 1..MAX_DIGITS are handled.

## Interface

- MAX_DIGITS, 6, maximum accepted digits per number; legal range 1..6 (999999 < 2^20, so no accumulator overflow is possible)
- TERM_CHAR, 8'h0D, terminator byte (CR)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  8  ASCII character
- in_valid  input  1  in_data valid
- in_ready  output  1  parser can accept a character this cycle
- out_value  output  20  parsed binary value
- out_count  output  3  number of digits accepted (0..MAX_DIGITS)
- out_error  output  1  number was malformed
- out_valid  output  1  result valid, held until accepted
- out_ready  input  1  downstream accepts result

## Operation

- Character accepted when in_valid && in_ready. Digit = 8'h30..8'h39, value in_data - 8'h30.
- Accumulate: acc_next = acc*10 + digit, computed as (acc<<3)+(acc<<1)+digit, 20 bits.
- States:
  - IDLE: acc=0, cnt=0, err=0. Digit -> acc=digit, cnt=1, ACCUM. TERM_CHAR -> result {value 0, count 0, error 1}, DONE. Other byte -> err=1, FLUSH.
  - ACCUM: digit with cnt<MAX_DIGITS -> accumulate, cnt+1. Digit with cnt==MAX_DIGITS -> err=1, FLUSH (cnt unchanged). TERM_CHAR -> result {acc, cnt, 0}, DONE. Other byte -> err=1, FLUSH.
  - FLUSH: consume and discard every byte until TERM_CHAR; then result {value 0, count = cnt at error point, error 1}, DONE.
  - DONE: out_valid=1, outputs stable. On out_ready -> clear acc/cnt/err, IDLE.
- Any error forces out_value=0.
- in_ready = 1 in IDLE, ACCUM, FLUSH; 0 in DONE.
- out_value/out_count/out_error are registered; they hold the last result outside DONE but are qualified only by out_valid.

## Timing

- Reset (async assert, sync release by clk): state IDLE, in_ready 1, out_valid 0, out_value 0, out_count 0, out_error 0, acc/cnt/err 0.
- One character per cycle, no bubbles while in_ready.
- Latency: terminator accepted at edge N -> out_valid=1 after edge N (visible cycle N+1).
- Result accepted at edge M (out_valid && out_ready) -> out_valid=0, in_ready=1 from cycle M+1; earliest next character accepted at edge M+1. No input/output overlap in the same cycle.
- in_valid held while in_ready=0: in_data must remain stable; no character is lost or duplicated.
- out_ready asserted while out_valid=0: ignored.
- rst_n asserted mid-number or in DONE: partial number and pending result discarded immediately; no out_valid pulse.

## Test plan

- "1","2","3",CR back-to-back -> out_value 20'h0007B, out_count 3, out_error 0, out_valid one cycle after CR.
- "9"x6, CR -> out_value 20'hF423F, out_count 6, out_error 0; then "0",CR -> 20'h00000, count 1, error 0.
- "1".."7" (7 digits), CR -> out_value 0, out_count 6, out_error 1; next "5",CR -> 20'h00005, error 0.
- "1","2","A","4",CR -> out_value 0, out_count 2, out_error 1, "4" discarded; lone CR -> value 0, count 0, error 1.
- Result pending, out_ready low 5 cycles, in_valid=1 with "7" -> in_ready 0, outputs stable 5 cycles; after acceptance "7" consumed exactly once, then CR -> 20'h00007.
- "4","5" then rst_n pulse low, then "8",CR -> out_value 20'h00008, count 1; no output during/after reset before CR.
